// File: rtl/obstacle_manager.sv
// Obstacle field manager: NUM_OBS slots that spawn, scroll left and despawn on the game tick, with a speed ramp.
// Latency: one cycle; every output is registered and reflects a qualifying game_tick on the following cycle.
// Backpressure: none; game_frozen stalls all state, and game_start restarts the field over tick or freeze.
module obstacle_manager #(
    parameter int NUM_OBS    = 4,
    parameter int CONV       = 2,
    parameter int X_START    = 160,
    parameter int SPAWN_LINE = 70,
    parameter int MIN_GAP    = 20,
    parameter int NUM_TYPES  = 6,
    parameter int SPEED_INIT = 1,
    parameter int SPEED_MAX  = 4,
    parameter int RAMP_TICKS = 600
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          game_tick,
    input  logic                          game_start,
    input  logic                          game_frozen,
    input  logic [7:0]                    rng,
    output logic [NUM_OBS*(10-CONV)-1:0]  obs_pos,
    output logic [NUM_OBS*3-1:0]          obs_type,
    output logic [NUM_OBS-1:0]            obs_active,
    output logic [2:0]                    speed,
    output logic                          spawn_pulse
);

    localparam int POS_W  = 10 - CONV;
    localparam int TYPE_W = 3;
    localparam int SPD_W  = 3;
    localparam int IDX_W  = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
    // Countdown must hold MIN_GAP plus the largest random extra (31).
    localparam int CD_W   = $clog2(MIN_GAP + 32);
    localparam int RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

    localparam logic [POS_W-1:0]  POS_OFF      = '1;
    localparam logic [POS_W-1:0]  X_START_P    = POS_W'(X_START);
    localparam logic [POS_W-1:0]  SPAWN_LINE_P = POS_W'(SPAWN_LINE);
    localparam logic [CD_W-1:0]   MIN_GAP_P    = CD_W'(MIN_GAP);
    localparam logic [SPD_W-1:0]  SPEED_INIT_P = SPD_W'(SPEED_INIT);
    localparam logic [SPD_W-1:0]  SPEED_MAX_P  = SPD_W'(SPEED_MAX);
    localparam logic [RAMP_W-1:0] RAMP_LAST    = RAMP_W'(RAMP_TICKS - 1);
    localparam logic [TYPE_W:0]   NUM_TYPES_P  = 4'(NUM_TYPES);

    typedef struct packed {
        logic              active;
        logic [POS_W-1:0]  pos;
        logic [TYPE_W-1:0] kind;
    } slot_t;

    localparam slot_t SLOT_IDLE = '{active: 1'b0, pos: POS_OFF, kind: '0};

    slot_t             slot_q [NUM_OBS];
    slot_t             slot_d [NUM_OBS];
    logic [CD_W-1:0]   cd_q, cd_d;
    logic [RAMP_W-1:0] ramp_q, ramp_d;
    logic [SPD_W-1:0]  speed_q, speed_d;
    logic              pulse_q, pulse_d;

    logic [POS_W-1:0]  speed_ext;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              line_clear;
    logic              spawn_go;
    logic [TYPE_W-1:0] spawn_kind;
    logic [CD_W-1:0]   cd_reload;

    assign speed_ext = POS_W'(speed_q);

    // Types 0..NUM_TYPES-1 pass through; the few codes above fold back down by NUM_TYPES.
    assign spawn_kind = ({1'b0, rng[2:0]} < NUM_TYPES_P) ? rng[2:0]
                                                         : rng[2:0] - NUM_TYPES_P[TYPE_W-1:0];
    assign cd_reload  = MIN_GAP_P + CD_W'(rng[7:3]);

    // Spawn qualification from the pre-tick state: lowest free slot and clear spawn line.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        line_clear = 1'b1;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (!slot_q[i].active) begin
                if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = IDX_W'(i);
                end
            end else if (slot_q[i].pos > SPAWN_LINE_P) begin
                line_clear = 1'b0;
            end
        end
        spawn_go = (cd_q == '0) && free_found && line_clear;
    end

    // Next-state: restart beats freeze, freeze beats tick; a tick scrolls, spawns and ramps.
    always_comb begin
        slot_d  = slot_q;
        cd_d    = cd_q;
        ramp_d  = ramp_q;
        speed_d = speed_q;
        pulse_d = 1'b0;
        if (game_start) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                slot_d[i] = SLOT_IDLE;
            end
            cd_d    = MIN_GAP_P;
            ramp_d  = '0;
            speed_d = SPEED_INIT_P;
        end else if (!game_frozen && game_tick) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                if (slot_q[i].active) begin
                    // Left-edge despawn; the slot stays unusable until the next tick.
                    if (slot_q[i].pos < speed_ext) begin
                        slot_d[i].active = 1'b0;
                        slot_d[i].pos    = POS_OFF;
                    end else begin
                        slot_d[i].pos = slot_q[i].pos - speed_ext;
                    end
                end else if (spawn_go && (free_idx == IDX_W'(i))) begin
                    slot_d[i].active = 1'b1;
                    slot_d[i].pos    = X_START_P;
                    slot_d[i].kind   = spawn_kind;
                end
            end
            // With every slot full the countdown parks at zero so spawn retries each tick.
            if (spawn_go) begin
                cd_d = cd_reload;
            end else if (cd_q != '0) begin
                cd_d = cd_q - CD_W'(1);
            end
            pulse_d = spawn_go;
            // New speed only moves obstacles from the next tick onward.
            if (ramp_q == RAMP_LAST) begin
                ramp_d = '0;
                if (speed_q < SPEED_MAX_P) begin
                    speed_d = speed_q + SPD_W'(1);
                end
            end else begin
                ramp_d = ramp_q + RAMP_W'(1);
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                slot_q[i] <= SLOT_IDLE;
            end
            cd_q    <= MIN_GAP_P;
            ramp_q  <= '0;
            speed_q <= SPEED_INIT_P;
            pulse_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_OBS; i++) begin
                slot_q[i] <= slot_d[i];
            end
            cd_q    <= cd_d;
            ramp_q  <= ramp_d;
            speed_q <= speed_d;
            pulse_q <= pulse_d;
        end
    end

    // Flatten slot registers onto the packed output buses.
    always_comb begin
        obs_pos    = '0;
        obs_type   = '0;
        obs_active = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            obs_pos[i*POS_W +: POS_W]   = slot_q[i].pos;
            obs_type[i*TYPE_W +: TYPE_W] = slot_q[i].kind;
            obs_active[i]               = slot_q[i].active;
        end
    end

    assign speed       = speed_q;
    assign spawn_pulse = pulse_q;

endmodule

// File: tb/tb_obstacle_manager.sv
// Directed bench for obstacle_manager: table of spawn vectors plus hand sequences.
// Three instances share stimulus: default, wide spawn line, and fast start speed.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_obstacle_manager;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        game_tick, game_start, game_frozen;
    logic [7:0]  rng;

    logic [31:0] a_pos, b_pos, c_pos;
    logic [11:0] a_type, b_type, c_type;
    logic [3:0]  a_active, b_active, c_active;
    logic [2:0]  a_speed, b_speed, c_speed;
    logic        a_pulse, b_pulse, c_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    obstacle_manager u_dut_a (
        .clk(clk), .rst_n(rst_n), .game_tick(game_tick), .game_start(game_start),
        .game_frozen(game_frozen), .rng(rng), .obs_pos(a_pos), .obs_type(a_type),
        .obs_active(a_active), .speed(a_speed), .spawn_pulse(a_pulse)
    );

    obstacle_manager #(.SPAWN_LINE(255)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .game_tick(game_tick), .game_start(game_start),
        .game_frozen(game_frozen), .rng(rng), .obs_pos(b_pos), .obs_type(b_type),
        .obs_active(b_active), .speed(b_speed), .spawn_pulse(b_pulse)
    );

    obstacle_manager #(.SPEED_INIT(3), .X_START(161)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .game_tick(game_tick), .game_start(game_start),
        .game_frozen(game_frozen), .rng(rng), .obs_pos(c_pos), .obs_type(c_type),
        .obs_active(c_active), .speed(c_speed), .spawn_pulse(c_pulse)
    );

    typedef struct {
        logic [7:0] rng_val;
        logic [2:0] exp_type;
        int         exp_gap;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // n consecutive tick cycles; returns on the falling edge after the last one.
    task automatic tick_n(input int n);
        @(negedge clk);
        game_tick = 1'b1;
        repeat (n) @(negedge clk);
        game_tick = 1'b0;
    endtask

    task automatic start_game();
        @(negedge clk);
        game_start = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        logic got;

        vecs[0] = '{rng_val: 8'h00, exp_type: 3'd0, exp_gap: 21};
        vecs[1] = '{rng_val: 8'h07, exp_type: 3'd1, exp_gap: 21};
        vecs[2] = '{rng_val: 8'hFB, exp_type: 3'd3, exp_gap: 52};
        vecs[3] = '{rng_val: 8'h06, exp_type: 3'd0, exp_gap: 21};
        vecs[4] = '{rng_val: 8'h2C, exp_type: 3'd4, exp_gap: 26};
        vecs[5] = '{rng_val: 8'h0D, exp_type: 3'd5, exp_gap: 22};

        rst_n = 1'b0; game_tick = 1'b0; game_start = 1'b0; game_frozen = 1'b0; rng = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_active", 32'(a_active), 32'h0);
        check("rst_pos",    a_pos, 32'hFFFF_FFFF);
        check("rst_type",   32'(a_type), 32'h0);
        check("rst_speed",  32'(a_speed), 32'd1);
        check("rst_pulse",  32'(a_pulse), 32'h0);
        rst_n = 1'b1;

        // Spawn table: first spawn on tick 21, type mapping, and reload gap to the next spawn.
        for (int v = 0; v < 6; v++) begin
            rng = 8'h00;
            start_game();
            tick_n(20);
            check($sformatf("v%0d_nospawn_t20", v), 32'(a_active), 32'h0);
            rng = vecs[v].rng_val;
            tick_n(1);
            check($sformatf("v%0d_active", v), 32'(a_active), 32'h1);
            check($sformatf("v%0d_pos", v),    32'(a_pos[7:0]), 32'd160);
            check($sformatf("v%0d_type", v),   32'(a_type[2:0]), 32'(vecs[v].exp_type));
            check($sformatf("v%0d_pulse", v),  32'(a_pulse), 32'h1);
            @(negedge clk);
            check($sformatf("v%0d_pulse_off", v), 32'(a_pulse), 32'h0);
            rng = 8'h00;
            gap = 0;
            got = 1'b0;
            for (int k = 1; k <= 100 && !got; k++) begin
                tick_n(1);
                if (b_pulse) begin
                    got = 1'b1;
                    gap = k;
                end
            end
            check($sformatf("v%0d_gap", v), 32'(gap), 32'(vecs[v].exp_gap));
        end

        // Scroll, spawn line and left-edge despawn.
        rng = 8'h07;
        start_game();
        tick_n(21);
        check("scr_a_pos_t21",  32'(a_pos[7:0]), 32'd160);
        check("scr_c_pos_t21",  32'(c_pos[7:0]), 32'd161);
        tick_n(52);
        check("scr_c_pos_t73",  32'(c_pos[7:0]), 32'd5);
        check("scr_c_speed",    32'(c_speed), 32'd3);
        tick_n(1);
        check("scr_c_pos_t74",  32'(c_pos[7:0]), 32'd2);
        check("scr_c_act_t74",  32'(c_active[0]), 32'h1);
        tick_n(1);
        check("scr_c_act_t75",  32'(c_active), 32'h2);
        check("scr_c_pos_t75",  32'(c_pos[7:0]), 32'hFF);
        check("scr_c_type_t75", 32'(c_type[2:0]), 32'd1);
        tick_n(36);
        check("line_a_pos_t111", 32'(a_pos[7:0]), 32'd70);
        check("line_a_act_t111", 32'(a_active), 32'h1);
        check("line_a_pulse_t111", 32'(a_pulse), 32'h0);
        tick_n(1);
        check("line_a_act_t112", 32'(a_active), 32'h3);
        check("line_a_pos_t112", 32'(a_pos[15:0]), 32'hA045);
        check("line_a_pulse_t112", 32'(a_pulse), 32'h1);
        tick_n(69);
        check("scr_a_pos_t181", 32'(a_pos[7:0]), 32'd0);
        check("scr_a_act_t181", 32'(a_active[0]), 32'h1);
        tick_n(1);
        check("scr_a_act_t182",  32'(a_active), 32'h2);
        check("scr_a_pos_t182",  32'(a_pos[7:0]), 32'hFF);
        check("scr_a_type_t182", 32'(a_type[2:0]), 32'd1);
        check("scr_a_speed",     32'(a_speed), 32'd1);

        // Fill every slot (wide spawn line), freeze, then reuse the freed slot.
        rng = 8'h00;
        start_game();
        tick_n(84);
        check("fill_act_t84",   32'(b_active), 32'hF);
        check("fill_pos_t84",   b_pos, 32'hA08B_7661);
        check("fill_pulse_t84", 32'(b_pulse), 32'h1);
        game_frozen = 1'b1;
        tick_n(100);
        check("frz_pos",   b_pos, 32'hA08B_7661);
        check("frz_act",   32'(b_active), 32'hF);
        check("frz_pulse", 32'(b_pulse), 32'h0);
        game_frozen = 1'b0;
        tick_n(21);
        check("full_act_t105",   32'(b_active), 32'hF);
        check("full_pulse_t105", 32'(b_pulse), 32'h0);
        tick_n(76);
        check("full_pos_t181", 32'(b_pos[7:0]), 32'd0);
        tick_n(1);
        check("full_act_t182",   32'(b_active), 32'hE);
        check("full_pos_t182",   32'(b_pos[7:0]), 32'hFF);
        check("full_pulse_t182", 32'(b_pulse), 32'h0);
        tick_n(1);
        check("full_act_t183",   32'(b_active), 32'hF);
        check("full_pos_t183",   32'(b_pos[7:0]), 32'd160);
        check("full_pulse_t183", 32'(b_pulse), 32'h1);

        // Restart wins over a same-cycle tick and freeze.
        @(negedge clk);
        game_start = 1'b1; game_tick = 1'b1; game_frozen = 1'b1;
        @(negedge clk);
        game_start = 1'b0; game_tick = 1'b0; game_frozen = 1'b0;
        check("gs_act",   32'(b_active), 32'h0);
        check("gs_pos",   b_pos, 32'hFFFF_FFFF);
        check("gs_speed", 32'(b_speed), 32'd1);
        check("gs_pulse", 32'(b_pulse), 32'h0);
        tick_n(20);
        check("gs_nospawn_t20", 32'(b_active), 32'h0);
        tick_n(1);
        check("gs_spawn_t21", 32'(b_active), 32'h1);

        // Speed ramp, frozen ticks do not advance it, saturation at the ceiling.
        start_game();
        tick_n(599);
        check("ramp_t599", 32'(a_speed), 32'd1);
        game_frozen = 1'b1;
        tick_n(5);
        check("ramp_frozen", 32'(a_speed), 32'd1);
        game_frozen = 1'b0;
        tick_n(1);
        check("ramp_t600",   32'(a_speed), 32'd2);
        check("ramp_c_t600", 32'(c_speed), 32'd4);
        tick_n(600);
        check("ramp_t1200", 32'(a_speed), 32'd3);
        tick_n(600);
        check("ramp_t1800", 32'(a_speed), 32'd4);
        tick_n(600);
        check("ramp_t2400", 32'(a_speed), 32'd4);
        tick_n(600);
        check("ramp_t3000",   32'(a_speed), 32'd4);
        check("ramp_c_t3000", 32'(c_speed), 32'd4);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_speed",   32'(a_speed), 32'd1);
        check("arst_c_speed", 32'(c_speed), 32'd3);
        check("arst_act",     32'(a_active), 32'h0);
        check("arst_pos",     a_pos, 32'hFFFF_FFFF);
        rst_n = 1'b1;

        start_game();
        tick_n(21);
        check("arst_pulse_before", 32'(a_pulse), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pulse_after", 32'(a_pulse), 32'h0);
        check("arst_act_after",   32'(a_active), 32'h0);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
